// File: rtl/rnn_pkg.sv
// Shared sizes and state encoding for the RNN datapath stages.
package rnn_pkg;
  localparam int DATA_W  = 16;
  localparam int N_DENSE = 24;
  localparam int N_VAD   = 24;
  localparam int N_FEAT  = 42;
  localparam int N_TOTAL = N_DENSE + N_VAD + N_FEAT;

  typedef enum logic {COLLECT = 1'b0, STREAM = 1'b1} asm_state_e;
endpackage

// File: rtl/vec_capture_bank.sv
// One source vector: register bank, have flag, ready, and element read by index.
module vec_capture_bank #(
  parameter int N      = 24,
  parameter int DATA_W = 16,
  parameter int IW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                collect,
  input  logic                clear,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                have,
  input  logic [IW-1:0]       rd_idx,
  output logic [DATA_W-1:0]   rd_data
);
  logic [N-1:0][DATA_W-1:0] bank;
  logic                     capture;

  // Ready is gated by rst so nothing handshakes during the reset cycle.
  assign in_ready = ~rst & collect & ~have;
  assign capture  = in_valid & in_ready;
  assign rd_data  = bank[rd_idx];

  // Data bank carries no reset; only the flag qualifies it.
  always_ff @(posedge clk)
    if (capture) bank <= in_data;

  always_ff @(posedge clk)
    if (rst)          have <= 1'b0;
    else if (clear)   have <= 1'b0;
    else if (capture) have <= 1'b1;
endmodule

// File: rtl/noise_input_assembler.sv
// Collects dense1 / VAD state / feature vectors, then streams their
// 90-element concatenation one element per beat to the noise GRU.
module noise_input_assembler import rnn_pkg::*; #(
  parameter int DATA_W  = rnn_pkg::DATA_W,
  parameter int N_DENSE = rnn_pkg::N_DENSE,
  parameter int N_VAD   = rnn_pkg::N_VAD,
  parameter int N_FEAT  = rnn_pkg::N_FEAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_DENSE*DATA_W-1:0] dense_data,
  input  logic                      dense_valid,
  output logic                      dense_ready,
  input  logic [N_VAD*DATA_W-1:0]   vad_data,
  input  logic                      vad_valid,
  output logic                      vad_ready,
  input  logic [N_FEAT*DATA_W-1:0]  feat_data,
  input  logic                      feat_valid,
  output logic                      feat_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [6:0]                out_index,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      frame_done
);
  localparam int N_TOT = N_DENSE + N_VAD + N_FEAT;
  localparam int IDX_W = 7;
  localparam int DW    = $clog2(N_DENSE);
  localparam int VW    = $clog2(N_VAD);
  localparam int FW    = $clog2(N_FEAT);

  asm_state_e        state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              collect, beat, last, clear, cap_all;
  logic              have_d, have_v, have_f;
  logic [DATA_W-1:0] rd_d, rd_v, rd_f;

  assign collect   = (state == COLLECT);
  assign out_valid = (state == STREAM);
  assign out_index = idx;
  assign beat      = out_valid & out_ready;
  assign last      = (idx == IDX_W'(N_TOT - 1));
  assign out_last  = out_valid & last;
  assign clear     = beat & last;

  // Flags as they will be after this edge, so a same-cycle final capture
  // moves straight to STREAM.
  assign cap_all = (have_d | (dense_valid & dense_ready)) &
                   (have_v | (vad_valid & vad_ready)) &
                   (have_f | (feat_valid & feat_ready));

  vec_capture_bank #(.N(N_DENSE), .DATA_W(DATA_W)) u_dense (
    .clk(clk), .rst(rst), .collect(collect), .clear(clear),
    .in_data(dense_data), .in_valid(dense_valid), .in_ready(dense_ready),
    .have(have_d), .rd_idx(DW'(idx)), .rd_data(rd_d));

  vec_capture_bank #(.N(N_VAD), .DATA_W(DATA_W)) u_vad (
    .clk(clk), .rst(rst), .collect(collect), .clear(clear),
    .in_data(vad_data), .in_valid(vad_valid), .in_ready(vad_ready),
    .have(have_v), .rd_idx(VW'(idx - IDX_W'(N_DENSE))), .rd_data(rd_v));

  vec_capture_bank #(.N(N_FEAT), .DATA_W(DATA_W)) u_feat (
    .clk(clk), .rst(rst), .collect(collect), .clear(clear),
    .in_data(feat_data), .in_valid(feat_valid), .in_ready(feat_ready),
    .have(have_f), .rd_idx(FW'(idx - IDX_W'(N_DENSE + N_VAD))), .rd_data(rd_f));

  always_comb begin
    out_data = rd_f;
    if (idx < IDX_W'(N_DENSE))              out_data = rd_d;
    else if (idx < IDX_W'(N_DENSE + N_VAD)) out_data = rd_v;
  end

  always_ff @(posedge clk)
    if (rst) state <= COLLECT;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (cap_all) state_nxt = STREAM;
      STREAM:  if (clear)   state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk)
    if (rst)       idx <= '0;
    else if (beat) idx <= last ? '0 : idx + 1'b1;

  always_ff @(posedge clk)
    if (rst) frame_done <= 1'b0;
    else     frame_done <= clear;
endmodule

// File: tb/tb_noise_input_assembler.sv
// Directed bench: frame-level model of the assembler checked every cycle,
// plus hand-computed expectations on the captured beat log.
module tb_noise_input_assembler;
  localparam int DW = 16, ND = 24, NV = 24, NF = 42, NT = 90;

  logic           clk = 1'b0;
  logic           rst;
  logic [ND*DW-1:0] dense_data;
  logic [NV*DW-1:0] vad_data;
  logic [NF*DW-1:0] feat_data;
  logic           dense_valid, vad_valid, feat_valid;
  logic           dense_ready, vad_ready, feat_ready;
  logic [DW-1:0]  out_data;
  logic [6:0]     out_index;
  logic           out_valid, out_ready, out_last, frame_done;

  noise_input_assembler dut (
    .clk(clk), .rst(rst),
    .dense_data(dense_data), .dense_valid(dense_valid), .dense_ready(dense_ready),
    .vad_data(vad_data), .vad_valid(vad_valid), .vad_ready(vad_ready),
    .feat_data(feat_data), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: which sources are held, the assembled vector, stream position.
  logic [DW-1:0] mvec [NT];
  bit  got_d, got_v, got_f, mdone, minit;
  int  mpos = -1;

  always @(posedge clk) begin
    if (rst) begin
      got_d = 0; got_v = 0; got_f = 0; mpos = -1; mdone = 0; minit = 1;
    end else if (minit) begin
      mdone = 0;
      if (mpos >= 0) begin
        if (out_ready) begin
          if (mpos == NT-1) begin
            mpos = -1; got_d = 0; got_v = 0; got_f = 0; mdone = 1;
          end else mpos++;
        end
      end else begin
        if (dense_valid && !got_d) begin
          got_d = 1;
          for (int i = 0; i < ND; i++) mvec[i] = dense_data[i*DW +: DW];
        end
        if (vad_valid && !got_v) begin
          got_v = 1;
          for (int i = 0; i < NV; i++) mvec[ND+i] = vad_data[i*DW +: DW];
        end
        if (feat_valid && !got_f) begin
          got_f = 1;
          for (int i = 0; i < NF; i++) mvec[ND+NV+i] = feat_data[i*DW +: DW];
        end
        if (got_d && got_v && got_f) mpos = 0;
      end
    end
  end

  int bidx[$];
  int bdat[$];
  int nlast = 0;

  always @(negedge clk) if (minit) begin
    chk("dense_ready", dense_ready, !rst && mpos < 0 && !got_d);
    chk("vad_ready",   vad_ready,   !rst && mpos < 0 && !got_v);
    chk("feat_ready",  feat_ready,  !rst && mpos < 0 && !got_f);
    chk("out_valid",   out_valid,   mpos >= 0);
    chk("out_last",    out_last,    mpos == NT-1);
    chk("frame_done",  frame_done,  mdone);
    if (mpos >= 0) begin
      chk("out_index", out_index, mpos);
      chk("out_data",  out_data,  mvec[mpos]);
    end
    if (!rst && out_valid && out_ready) begin
      bidx.push_back(int'(out_index));
      bdat.push_back(int'(out_data));
      if (out_last) nlast++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_data(input int db, input int vb, input int fb);
    for (int i = 0; i < ND; i++) dense_data[i*DW +: DW] = 16'(db + i);
    for (int i = 0; i < NV; i++) vad_data[i*DW +: DW]   = 16'(vb + i);
    for (int i = 0; i < NF; i++) feat_data[i*DW +: DW]  = 16'(fb + i);
  endtask

  task automatic load(input int db, input int vb, input int fb);
    set_data(db, vb, fb);
    dense_valid = 1; vad_valid = 1; feat_valid = 1;
    tick();
    dense_valid = 0; vad_valid = 0; feat_valid = 0;
  endtask

  // Runs until the cycle after frame_done; bp selects the 1,0,0,1 out_ready pattern.
  task automatic wait_done(input string nm, input bit bp, input int lim);
    bit seen = 0;
    for (int c = 0; c < lim && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
      tick();
      out_ready = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
    end
    out_ready = 1;
    chk({nm, "_done_seen"}, seen, 1);
  endtask

  task automatic chk_frame(input string nm, input int db, input int vb, input int fb);
    int bad = 0;
    chk({nm, "_beats"}, bidx.size(), NT);
    for (int k = 0; k < bidx.size(); k++) if (bidx[k] != k) bad++;
    chk({nm, "_seq"}, bad, 0);
    if (bdat.size() == NT) begin
      chk({nm, "_d0"},  bdat[0],  db);
      chk({nm, "_d23"}, bdat[23], db + 23);
      chk({nm, "_v0"},  bdat[24], vb);
      chk({nm, "_v23"}, bdat[47], vb + 23);
      chk({nm, "_f0"},  bdat[48], fb);
      chk({nm, "_f41"}, bdat[89], fb + 41);
    end
    chk({nm, "_last"}, nlast, 1);
    bidx.delete(); bdat.delete(); nlast = 0;
  endtask

  initial begin
    rst = 1; out_ready = 1;
    dense_valid = 0; vad_valid = 0; feat_valid = 0;
    set_data(0, 0, 0);
    tick(); tick();
    rst = 0;

    // Simultaneous arrival, element i = i.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dense_ready", dense_ready, 1);
    @(posedge clk); #1;
    set_data(0, 0, 0);
    dense_valid = 1; vad_valid = 1; feat_valid = 1;
    @(negedge clk);
    chk("sim_c0_ready", {dense_ready, vad_ready, feat_ready}, 3'b111);
    tick();
    dense_valid = 0; vad_valid = 0; feat_valid = 0;
    @(negedge clk);
    chk("sim_c1_valid", out_valid, 1);
    chk("sim_c1_index", out_index, 0);
    tick();
    wait_done("sim", 0, 200);
    chk_frame("sim", 0, 0, 0);

    // Staggered arrival: feat@0, dense@5, vad@12.
    set_data(16'h0100, 16'h0200, 16'h0300);
    for (int c = 0; c <= 13; c++) begin
      feat_valid  = (c == 0);
      dense_valid = (c == 5);
      vad_valid   = (c == 12);
      @(negedge clk);
      if (c == 1)  chk("stg_feat_ready_c1", feat_ready, 0);
      if (c == 6)  chk("stg_dense_ready_c6", dense_ready, 0);
      if (c == 12) chk("stg_valid_c12", out_valid, 0);
      if (c == 13) chk("stg_valid_c13", out_valid, 1);
      tick();
    end
    feat_valid = 0; dense_valid = 0; vad_valid = 0;
    wait_done("stg", 0, 200);
    chk_frame("stg", 16'h0100, 16'h0200, 16'h0300);

    // Backpressure with out_ready 1,0,0,1.
    load(16'h0400, 16'h0500, 16'h0600);
    wait_done("bp", 1, 600);
    chk_frame("bp", 16'h0400, 16'h0500, 16'h0600);

    // Second frame offered early on dense while the first streams.
    load(16'h0700, 16'h0800, 16'h0900);
    set_data(16'h1000, 16'h2000, 16'h3000);
    dense_valid = 1;
    wait_done("early1", 0, 200);
    dense_valid = 0;
    chk_frame("early1", 16'h0700, 16'h0800, 16'h0900);
    vad_valid = 1; feat_valid = 1;
    tick();
    vad_valid = 0; feat_valid = 0;
    wait_done("early2", 0, 200);
    chk_frame("early2", 16'h1000, 16'h2000, 16'h3000);

    // Reset while streaming at index 37.
    load(16'h0a00, 16'h0b00, 16'h0c00);
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_index == 7'd37) break;
      tick();
    end
    chk("rstm_at37", out_index, 37);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rstm_out_valid", out_valid, 0);
    chk("rstm_readies", {dense_ready, vad_ready, feat_ready}, 3'b111);
    chk("rstm_no_done", frame_done, 0);
    tick();
    bidx.delete(); bdat.delete(); nlast = 0;
    load(16'h0d00, 16'h0e00, 16'h0f00);
    wait_done("fresh", 0, 200);
    chk_frame("fresh", 16'h0d00, 16'h0e00, 16'h0f00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
